// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry and a one-cycle registered prediction.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef HBIT_ADDR
`define HBIT_ADDR (`SIZE_ADDR - 1)
`endif

module branch_predictor #(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] CTR_INIT   = 2'b10
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  input  logic                  iw_fetch_valid,
  input  logic [`HBIT_ADDR:0]   iw_fetch_pc,
  input  logic                  iw_flush,
  input  logic                  iw_clear,
  input  logic                  iw_update,
  input  logic [`HBIT_ADDR:0]   iw_update_pc,
  input  logic                  iw_update_taken,
  input  logic [`HBIT_ADDR:0]   iw_update_target,
  output logic                  ow_pred_valid,
  output logic                  ow_pred_hit,
  output logic                  ow_pred_taken,
  output logic [`HBIT_ADDR:0]   ow_pred_pc
);

  localparam int ADDR_W  = `SIZE_ADDR;
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_W - INDEX_BITS;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [ADDR_W-1:0]  target [ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Stage p0: combinational lookup against current (pre-update) table state
  logic [INDEX_BITS-1:0] fetch_idx_p0;
  logic [TAG_W-1:0]      fetch_tag_p0;
  logic                  hit_p0;
  logic                  taken_p0;
  logic [ADDR_W-1:0]     npc_p0;
  logic                  vld_p0;

  always_comb begin
    fetch_idx_p0 = iw_fetch_pc[INDEX_BITS-1:0];
    fetch_tag_p0 = iw_fetch_pc[ADDR_W-1:INDEX_BITS];
    hit_p0       = valid[fetch_idx_p0] && (tag[fetch_idx_p0] == fetch_tag_p0);
    taken_p0     = hit_p0 && ctr[fetch_idx_p0][1];
    npc_p0       = taken_p0 ? target[fetch_idx_p0] : iw_fetch_pc + ADDR_W'(1);
    vld_p0       = iw_fetch_valid && !iw_flush;
  end

  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic                  upd_en;
  logic                  upd_alloc;

  // A same-cycle clear suppresses training entirely
  always_comb begin
    upd_idx   = iw_update_pc[INDEX_BITS-1:0];
    upd_tag   = iw_update_pc[ADDR_W-1:INDEX_BITS];
    upd_hit   = valid[upd_idx] && (tag[upd_idx] == upd_tag);
    upd_en    = iw_update && !iw_clear;
    upd_alloc = upd_en && !upd_hit && iw_update_taken;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else begin
      if (iw_clear) begin
        valid <= '0;
      end else if (upd_alloc) begin
        valid[upd_idx] <= 1'b1;
      end
      if (upd_en && upd_hit) begin
        ctr[upd_idx] <= iw_update_taken ? sat_inc(ctr[upd_idx]) : sat_dec(ctr[upd_idx]);
      end else if (upd_alloc) begin
        ctr[upd_idx] <= CTR_INIT;
      end
    end
  end

  // Tag and target payload are don't-care until the valid bit is set
  always_ff @(posedge iw_clk) begin
    if (upd_en && iw_update_taken) begin
      tag[upd_idx]    <= upd_tag;
      target[upd_idx] <= iw_update_target;
    end
  end

  // Stage p1: registered prediction
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      ow_pred_valid <= 1'b0;
      ow_pred_hit   <= 1'b0;
      ow_pred_taken <= 1'b0;
      ow_pred_pc    <= '0;
    end else begin
      ow_pred_valid <= vld_p0;
      ow_pred_hit   <= iw_fetch_valid && hit_p0;
      ow_pred_taken <= iw_fetch_valid && taken_p0;
      if (iw_fetch_valid) ow_pred_pc <= npc_p0;
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Looks up the fetch PC and returns a registered prediction one cycle later. That prediction travels down the pipe as the `pred_taken`/`pred_pc` pair checked at branch resolution.
- Consumes the resolution-side update stream (`update`, `update_pc`, `update_taken`, `update_target`) to train the table.

Parameters:
- INDEX_BITS, 4, log2 of BTB entry count (ENTRIES = 2**INDEX_BITS = 16).
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- iw_clk  input  1  clock, rising edge.
- iw_rst_n  input  1  reset, asynchronous, active-low.
- iw_fetch_valid  input  1  lookup request this cycle.
- iw_fetch_pc  input  `SIZE_ADDR  PC to predict.
- iw_flush  input  1  pipeline redirect; squashes the prediction being registered this cycle.
- iw_clear  input  1  invalidate the whole BTB.
- iw_update  input  1  train request from branch resolution.
- iw_update_pc  input  `SIZE_ADDR  PC of resolved branch.
- iw_update_taken  input  1  resolved direction.
- iw_update_target  input  `SIZE_ADDR  resolved target.
- ow_pred_valid  output  1  registered prediction valid.
- ow_pred_hit  output  1  lookup hit a valid entry.
- ow_pred_taken  output  1  predicted taken.
- ow_pred_pc  output  `SIZE_ADDR  predicted next PC.

Behaviour:
- Storage per entry:
  - valid bit.
  - tag = pc[`HBIT_ADDR:INDEX_BITS].
  - target, `SIZE_ADDR wide.
  - ctr, 2 bits.
- Index = pc[INDEX_BITS-1:0].
- Reset (iw_rst_n low, asynchronous):
  - All valid bits = 0; all ctr = 2'b01.
  - ow_pred_valid = 0, ow_pred_hit = 0, ow_pred_taken = 0, ow_pred_pc = 0.
  - Target and tag contents are don't-care.
- Lookup, combinational read of current table state:
  - hit = valid[idx] && tag[idx] == fetch tag.
  - taken = hit && ctr[idx][1].
  - npc = taken ? target[idx] : iw_fetch_pc + `SIZE_ADDR'd1 (wraps modulo 2**`SIZE_ADDR).
- Output register, latency 1:
  - At each rising edge: ow_pred_valid <= iw_fetch_valid && !iw_flush.
  - When iw_fetch_valid: ow_pred_hit, ow_pred_taken and ow_pred_pc load the lookup results.
  - When !iw_fetch_valid: ow_pred_hit and ow_pred_taken load 0; ow_pred_pc holds its value.
  - iw_flush does not block table training.
- Update, applied at the rising edge when iw_update = 1; index/tag taken from iw_update_pc.
  - Hit, taken:
    - ctr saturating increment (3 stays 3).
    - target <= iw_update_target.
  - Hit, not taken:
    - ctr saturating decrement (0 stays 0).
    - target unchanged.
  - Miss, taken (allocate, overwriting any existing entry):
    - valid <= 1, tag <= update tag, target <= iw_update_target, ctr <= CTR_INIT.
  - Miss, not taken: no change; no allocation.
- Clear: iw_clear = 1 at an edge sets all valid bits to 0; ctr and targets are untouched.
- Simultaneous events:
  - iw_clear with iw_update in the same cycle: clear wins; the update is dropped.
  - Lookup and update to the same index in the same cycle: the lookup sees pre-update contents (no bypass). The registered prediction reflects the old entry; the new state is visible from the next lookup.
  - iw_clear with a lookup: the lookup uses pre-clear contents.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight prediction is lost (ow_pred_valid = 0).
- No backpressure: one lookup and one update are accepted every cycle.

Test Plan:
- After reset, fetch pc=0x0040 -> next cycle ow_pred_valid=1, hit=0, taken=0, pred_pc=0x0041.
- Update pc=0x0043, taken=1, target=0x0100. Then fetch 0x0043 -> hit=1, taken=1 (ctr=2), pred_pc=0x0100.
- Train 0x0043 not-taken twice (ctr 2->1->0), then fetch 0x0043 -> hit=1, taken=0, pred_pc=0x0044. Three further not-taken updates keep ctr at 0. Then three taken updates -> ctr 3, and a fourth taken keeps ctr at 3.
- Aliasing, after entry 0x0043 exists:
  - Update pc=0x0053, taken=1, target=0x0200 evicts it.
  - Fetch 0x0043 -> hit=0, pred_pc=0x0044.
  - Fetch 0x0053 -> pred_pc=0x0200.
  - Update pc=0x0063 not-taken -> entry unchanged.
- Same-cycle lookup and allocate of 0x0043 -> that prediction has hit=0; the next lookup gives hit=1. iw_flush with fetch_valid=1 -> ow_pred_valid=0.
- iw_clear with update pc=0x0043 taken in the same cycle -> afterwards fetch 0x0043 hits nothing. Assert iw_rst_n low between edges -> outputs zero immediately and all entries miss.
